// File: rtl/atomik_event_fifo.sv
// Event classifier + show-ahead FIFO with saturating stats; 1-cycle push-to-out_valid, out_ready stalls head, full drops+counts.
// Optional ATOMIK_ZERO_SUPPRESS_EN: zero-valued DELTA events are counted in cnt_zero_supp instead of queued.
module atomik_event_fifo #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ev_valid,
    input  logic                          ev_delta,
    input  logic                          ev_first_touch,
    input  logic                          ev_drop_invalid,
    input  logic [ADDR_W-1:0]             ev_addr,
    input  logic [3:0]                    ev_delta_val,
    input  logic                          ev_is_zero,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_W+5:0]             out_data,
    input  logic                          clr_stats,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow_sticky,
    output logic [CNT_W-1:0]              cnt_delta,
    output logic [CNT_W-1:0]              cnt_first,
    output logic [CNT_W-1:0]              cnt_invalid,
    output logic [CNT_W-1:0]              cnt_overflow,
    output logic [CNT_W-1:0]              cnt_zero_supp
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DW    = ADDR_W + 6;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_ONE : v;
    endfunction

    logic [DW-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] delta_q, delta_d, first_q, first_d, inv_q, inv_d, ovf_q, ovf_d;

    logic is_inv, is_first, is_delta, zero_supp, push_req, full, pop, push, ovf;
    logic [1:0]    ev_type;
    logic [DW-1:0] ev_entry;

    assign is_inv   = ev_valid && ev_drop_invalid;
    assign is_first = ev_valid && !ev_drop_invalid && ev_first_touch;
    assign is_delta = ev_valid && !ev_drop_invalid && !ev_first_touch && ev_delta;

`ifdef ATOMIK_ZERO_SUPPRESS_EN
    logic [CNT_W-1:0] zs_q, zs_d;
    assign zero_supp     = is_delta && ev_is_zero;
    assign cnt_zero_supp = zs_q;
`else
    logic unused_is_zero;
    assign unused_is_zero = ev_is_zero;
    assign zero_supp      = 1'b0;
    assign cnt_zero_supp  = '0;
`endif

    assign push_req = (is_inv || is_first || is_delta) && !zero_supp;
    assign ev_type  = is_inv ? 2'b10 : (is_first ? 2'b01 : 2'b00);
    assign ev_entry = {ev_type, ev_addr, (is_delta ? ev_delta_val : 4'h0)};

    assign out_valid = (level_q != '0);
    assign full      = (level_q == DEPTH_L);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = push_req && (!full || pop);
    assign ovf       = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ev_entry;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !pop)      level_d = level_q + LVL_ONE;
        else if (pop && !push) level_d = level_q - LVL_ONE;

        delta_d  = sat_inc(delta_q, is_delta);
        first_d  = sat_inc(first_q, is_first);
        inv_d    = sat_inc(inv_q, is_inv);
        ovf_d    = sat_inc(ovf_q, ovf);
        sticky_d = sticky_q || ovf;
`ifdef ATOMIK_ZERO_SUPPRESS_EN
        zs_d     = sat_inc(zs_q, zero_supp);
`endif
        if (clr_stats) begin
            delta_d  = '0;
            first_d  = '0;
            inv_d    = '0;
            ovf_d    = '0;
            sticky_d = 1'b0;
`ifdef ATOMIK_ZERO_SUPPRESS_EN
            zs_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sticky_q <= 1'b0;
            delta_q  <= '0;
            first_q  <= '0;
            inv_q    <= '0;
            ovf_q    <= '0;
`ifdef ATOMIK_ZERO_SUPPRESS_EN
            zs_q     <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
            delta_q  <= delta_d;
            first_q  <= first_d;
            inv_q    <= inv_d;
            ovf_q    <= ovf_d;
`ifdef ATOMIK_ZERO_SUPPRESS_EN
            zs_q     <= zs_d;
`endif
        end
    end

    // Empty FIFO (including during reset) presents all-zero data.
    assign out_data        = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level      = level_q;
    assign overflow_sticky = sticky_q;
    assign cnt_delta       = delta_q;
    assign cnt_first       = first_q;
    assign cnt_invalid     = inv_q;
    assign cnt_overflow    = ovf_q;
endmodule
